wb_bus_arbiter: RTL

Two-master, single-slave Wishbone arbiter that sits directly downstream of the `trivial_mips` core. It merges the core's instruction bus (`ibus_req`/`ibus_res`) and data bus (`dbus_req`/`dbus_res`) onto one shared system bus. Grants are single-transfer, with fair alternation between the two masters under contention. A bus-timeout watchdog keeps a dead slave from hanging the pipeline.

---
 rtl/wb_bus_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-master, single-slave Wishbone classic arbiter.
// Merges the instruction and data buses of the core onto one shared bus.
// Grants are single-transfer and alternate under contention.
// A watchdog aborts transfers that the slave never acknowledges.

package wb_bus_pkg;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } WishboneReq_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } WishboneRes_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

endpackage

// Handshake: a master requests while cyc & stb are high and holds every
// request field stable until it sees ack in the same cycle; ack completes
// exactly one transfer. Dropping cyc before ack abandons the transfer.
module wb_bus_arbiter
  import wb_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  WishboneReq_t ibus_req,
  output WishboneRes_t ibus_res,
  input  WishboneReq_t dbus_req,
  output WishboneRes_t dbus_res,
  output WishboneReq_t mbus_req,
  input  WishboneRes_t mbus_res,
  output logic         bus_timeout,
  output arb_state_t   state_dbg
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  arb_state_t   state;
  arb_state_t   state_next;
  logic         last_d;
  logic [15:0]  wdog_cnt;
  logic         req_i;
  logic         req_d;
  logic         timeout_fire;
  WishboneReq_t g_req;
  WishboneRes_t g_res;

  assign req_i     = ibus_req.cyc & ibus_req.stb;
  assign req_d     = dbus_req.cyc & dbus_req.stb;
  assign state_dbg = state;

  // State register, fairness bit and watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      last_d   <= 1'b0;
      wdog_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (state == ARB_IDLE) begin
        // Every grant is preceded by an IDLE cycle, so clearing here
        // starts each grant with a fresh count.
        wdog_cnt <= 16'd0;
        if (state_next == ARB_GRANT_D) begin
          last_d <= 1'b1;
        end else if (state_next == ARB_GRANT_I) begin
          last_d <= 1'b0;
        end
      end else if (!mbus_res.ack) begin
        // The grant ends no later than the cycle the count reaches the
        // limit, so the counter cannot wrap.
        wdog_cnt <= wdog_cnt + 16'd1;
      end
    end
  end

  // Next-state selection and combinational routing of the granted master.
  always_comb begin
    state_next   = state;
    g_req        = '0;
    g_res        = '0;
    mbus_req     = '0;
    ibus_res     = '0;
    dbus_res     = '0;
    bus_timeout  = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      ARB_IDLE: begin
        // Under contention, the master not served last goes next.
        if (req_d && (!req_i || !last_d)) begin
          state_next = ARB_GRANT_D;
        end else if (req_i) begin
          state_next = ARB_GRANT_I;
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        g_req        = (state == ARB_GRANT_D) ? dbus_req : ibus_req;
        // A slave ack in the limit cycle still completes normally.
        timeout_fire = (wdog_cnt == TIMEOUT_VAL) && !mbus_res.ack;
        mbus_req     = g_req;
        g_res        = mbus_res;
        if (timeout_fire) begin
          mbus_req.cyc = 1'b0;
          mbus_req.stb = 1'b0;
          g_res.ack    = 1'b1;
          g_res.data   = 32'hFFFF_FFFF;
        end
        bus_timeout = timeout_fire;
        if (state == ARB_GRANT_D) begin
          dbus_res = g_res;
        end else begin
          ibus_res = g_res;
        end
        if (mbus_res.ack || !g_req.cyc || timeout_fire) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule
